// File: rtl/debug_pkg.sv
// Shared definitions for the host-side debug controller: command bytes,
// state encoding and a constant log2 helper.
package debug_pkg;

   localparam logic [7:0] CMD_RESET = 8'h52;
   localparam logic [7:0] CMD_CONT  = 8'h43;
   localparam logic [7:0] CMD_STEP  = 8'h53;
   localparam logic [7:0] CMD_DUMP  = 8'h44;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RUN    = 3'd1;
   localparam logic [2:0] S_STEP   = 3'd2;
   localparam logic [2:0] S_DADDR  = 3'd3;
   localparam logic [2:0] S_DLATCH = 3'd4;
   localparam logic [2:0] S_DSEND  = 3'd5;

   typedef enum logic [2:0] {
      IDLE       = S_IDLE,
      RUN        = S_RUN,
      STEP       = S_STEP,
      DUMP_ADDR  = S_DADDR,
      DUMP_LATCH = S_DLATCH,
      DUMP_SEND  = S_DSEND
   } state_t;

   localparam int NB_REG_DFLT    = 32;
   localparam int NB_BYTE_DFLT   = 8;
   localparam int BYTES_PER_WORD = NB_REG_DFLT / NB_BYTE_DFLT;

   // Minimum of 1 so single-entry ranges still get a usable index width.
   function automatic int clogb2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/dbg_word_serializer.sv
// Loads a word and emits it MSB byte first over a valid/ready handshake;
// one_byte sends only the top byte (used for the trailing checksum).
module dbg_word_serializer
   import debug_pkg::*;
#(
   parameter int NB_BYTE = 8,
   parameter int NBYTES  = BYTES_PER_WORD
) (
   input  logic                      gclk,
   input  logic                      grst_n,
   input  logic                      clear,
   input  logic                      load,
   input  logic                      one_byte,
   input  logic [NB_BYTE*NBYTES-1:0] word,
   input  logic                      ready,
   output logic [NB_BYTE-1:0]        data,
   output logic                      valid,
   output logic                      last
);
   localparam int NB_WORD = NB_BYTE * NBYTES;
   localparam int NB_CNT  = clogb2(NBYTES);

   logic [NB_WORD-1:0] shreg;
   logic [NB_CNT-1:0]  remain;

   assign data = shreg[NB_WORD-1 -: NB_BYTE];
   assign last = (remain == '0);

   // clear beats load so an abort never leaves a freshly loaded byte pending
   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         shreg  <= '0;
         remain <= '0;
         valid  <= 1'b0;
      end else if (clear) begin
         shreg  <= '0;
         remain <= '0;
         valid  <= 1'b0;
      end else if (load) begin
         shreg  <= word;
         remain <= one_byte ? '0 : NB_CNT'(NBYTES - 1);
         valid  <= 1'b1;
      end else if (valid && ready) begin
         if (last) begin
            valid <= 1'b0;
         end else begin
            shreg  <= shreg << NB_BYTE;
            remain <= remain - NB_CNT'(1);
         end
      end
   end

endmodule

// File: rtl/debug_unit.sv
// Host debug controller: byte commands reset/run/step/dump the pipeline and
// stream a dump back. `define DEBUG_UNIT_CKSUM_EN appends an XOR checksum byte.
module debug_unit
   import debug_pkg::*;
#(
   parameter int NB_REG       = 32,
   parameter int NB_BYTE      = 8,
   parameter int N_DUMP_WORDS = 64,
   parameter int NB_DBG_ADDR  = clogb2(N_DUMP_WORDS)
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic [NB_BYTE-1:0]     i_rx_data,
   input  logic                   i_rx_valid,
   output logic [NB_BYTE-1:0]     o_tx_data,
   output logic                   o_tx_valid,
   input  logic                   i_tx_ready,
   output logic                   o_pipe_valid,
   output logic                   o_pipe_reset,
   input  logic                   i_halt,
   output logic [NB_DBG_ADDR-1:0] o_dbg_addr,
   input  logic [NB_REG-1:0]      i_dbg_data,
   output logic                   o_busy
);
   localparam int                 NB_WIDX   = clogb2(N_DUMP_WORDS + 1);
   localparam logic [NB_WIDX-1:0] LAST_WORD = NB_WIDX'(N_DUMP_WORDS);

   state_t              state;
   logic [NB_REG-1:0]   counter;
   logic [NB_WIDX-1:0]  widx;
   logic                cmd_reset, cmd_cont, cmd_step, cmd_dump;
   logic                xfer, ser_last, ser_load, ser_one;
   logic                word_done, dump_done;
   logic [NB_REG-1:0]   ser_word;
   logic [NB_REG-1:0]   data_word;

   assign cmd_reset = i_rx_valid && (i_rx_data == NB_BYTE'(CMD_RESET));
   assign cmd_cont  = i_rx_valid && (i_rx_data == NB_BYTE'(CMD_CONT));
   assign cmd_step  = i_rx_valid && (i_rx_data == NB_BYTE'(CMD_STEP));
   assign cmd_dump  = i_rx_valid && (i_rx_data == NB_BYTE'(CMD_DUMP));

   assign xfer      = o_tx_valid && i_tx_ready;
   assign word_done = (state == DUMP_SEND) && xfer && ser_last;

   // The counter only moves with o_pipe_valid, which is low throughout a
   // dump, so reading it live at word 0 equals the entry snapshot.
   assign data_word = (widx == '0) ? counter : i_dbg_data;

`ifdef DEBUG_UNIT_CKSUM_EN
   logic [NB_BYTE-1:0] cksum;
   logic               ck_phase;
   logic               ck_load;

   assign ck_load   = word_done && (widx == LAST_WORD) && !ck_phase;
   assign dump_done = word_done && (widx == LAST_WORD) && ck_phase;
   assign ser_load  = (state == DUMP_LATCH) || ck_load;
   assign ser_one   = ck_load;
   // Fold in the byte being accepted this cycle, the last one of the dump.
   assign ser_word  = ck_load ? {cksum ^ o_tx_data, {(NB_REG-NB_BYTE){1'b0}}}
                              : data_word;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         cksum    <= '0;
         ck_phase <= 1'b0;
      end else if (cmd_reset || state == IDLE) begin
         cksum    <= '0;
         ck_phase <= 1'b0;
      end else begin
         if (xfer)    cksum    <= cksum ^ o_tx_data;
         if (ck_load) ck_phase <= 1'b1;
      end
   end
`else
   assign dump_done = word_done && (widx == LAST_WORD);
   assign ser_load  = (state == DUMP_LATCH);
   assign ser_one   = 1'b0;
   assign ser_word  = data_word;
`endif

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state        <= IDLE;
         o_pipe_reset <= 1'b1;
         o_pipe_valid <= 1'b0;
         o_dbg_addr   <= '0;
         o_busy       <= 1'b0;
         counter      <= '0;
         widx         <= '0;
      end else begin
         o_pipe_reset <= 1'b0;
         o_pipe_valid <= 1'b0;
         if (o_pipe_valid) counter <= counter + NB_REG'(1);
         if (cmd_reset) begin
            o_pipe_reset <= 1'b1;
            counter      <= '0;
            o_dbg_addr   <= '0;
            widx         <= '0;
            o_busy       <= 1'b0;
            state        <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  widx <= '0;
                  if (cmd_cont) begin
                     state        <= RUN;
                     o_pipe_valid <= 1'b1;
                     o_busy       <= 1'b1;
                  end else if (cmd_step) begin
                     state        <= STEP;
                     o_pipe_valid <= 1'b1;
                     o_busy       <= 1'b1;
                  end else if (cmd_dump) begin
                     state  <= DUMP_ADDR;
                     o_busy <= 1'b1;
                  end
               end
               RUN: begin
                  if (i_halt) state        <= DUMP_ADDR;
                  else        o_pipe_valid <= 1'b1;
               end
               STEP:       state <= DUMP_ADDR;
               DUMP_ADDR:  state <= DUMP_LATCH;
               DUMP_LATCH: state <= DUMP_SEND;
               DUMP_SEND: begin
                  if (dump_done) begin
                     state      <= IDLE;
                     o_busy     <= 1'b0;
                     o_dbg_addr <= '0;
                     widx       <= '0;
                  end else if (word_done && widx != LAST_WORD) begin
                     // word widx+1 reads debug address widx
                     widx       <= widx + NB_WIDX'(1);
                     o_dbg_addr <= NB_DBG_ADDR'(widx);
                     state      <= DUMP_ADDR;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   dbg_word_serializer #(
      .NB_BYTE (NB_BYTE),
      .NBYTES  (NB_REG / NB_BYTE)
   ) u_ser (
      .gclk     (i_clock),
      .grst_n   (i_reset),
      .clear    (cmd_reset),
      .load     (ser_load),
      .one_byte (ser_one),
      .word     (ser_word),
      .ready    (i_tx_ready),
      .data     (o_tx_data),
      .valid    (o_tx_valid),
      .last     (ser_last)
   );

endmodule

// File: tb/tb_debug_unit.sv
// Randomized bench for debug_unit: expected dump bytes come from a command
// level model (cycle count + debug memory contents), checked byte by byte.
module tb_debug_unit;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        pipe_valid, pipe_reset, halt, busy;
   logic [1:0]  dbg_addr;
   logic [31:0] dbg_data;

   logic [31:0] mem [N];
   logic [31:0] mdl_cnt;
   logic [7:0]  got [$];
   int          n_chk = 0, n_pass = 0, pv_seen = 0, ready_mode = 0;
   logic        st_v = 1'b0, st_r = 1'b0, st_abort = 1'b0;
   logic [7:0]  st_d = 8'h00;

   debug_unit #(.NB_REG(32), .NB_BYTE(8), .N_DUMP_WORDS(N)) dut (
      .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
      .o_pipe_valid(pipe_valid), .o_pipe_reset(pipe_reset), .i_halt(halt),
      .o_dbg_addr(dbg_addr), .i_dbg_data(dbg_data), .o_busy(busy)
   );

   always #5 clk = ~clk;

   // debug port: data for an address appears one cycle later
   always @(posedge clk) dbg_data <= mem[dbg_addr];

   always @(negedge clk) begin
      case (ready_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = !tx_ready;
         default: tx_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
   endtask

   // sample just before each rising edge: record transfers, check stalls
   always @(negedge clk) begin
      #4;
      if (rst_n) begin
         if (pipe_valid) pv_seen++;
         if (st_v && !st_r && !st_abort) begin
            chk("stall_valid", 32'(tx_valid), 32'd1);
            chk("stall_data", 32'(tx_data), 32'(st_d));
         end
         if (tx_valid && tx_ready) got.push_back(tx_data);
         st_v     = tx_valid;
         st_r     = tx_ready;
         st_d     = tx_data;
         st_abort = rx_valid && (rx_data == 8'h52);
      end
   end

   task automatic send_cmd(input logic [7:0] c);
      @(negedge clk);
      rx_data  = c;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   // c: 'S', 'C' (halt after k valid cycles) or 'D'
   task automatic do_cmd(input logic [7:0] c, input int k);
      logic [7:0]  exp_q [$];
      logic [31:0] wd;
      logic [7:0]  ck;
      int          pv0, exp_pv;
      exp_pv = (c == 8'h53) ? 1 : (c == 8'h43) ? k : 0;
      mdl_cnt = mdl_cnt + 32'(exp_pv);
      ck = 8'h00;
      for (int w = 0; w <= N; w++) begin
         wd = (w == 0) ? mdl_cnt : mem[w-1];
         for (int b = 3; b >= 0; b--) begin
            exp_q.push_back(wd[8*b +: 8]);
            ck = ck ^ wd[8*b +: 8];
         end
      end
`ifdef DEBUG_UNIT_CKSUM_EN
      exp_q.push_back(ck);
`endif
      got.delete();
      pv0 = pv_seen;
      send_cmd(c);
      if (c == 8'h43) begin
         repeat (k - 1) @(negedge clk);
         halt = 1'b1;
      end
      wait_idle();
      halt = 1'b0;
      chk("pipe_valid_cycles", 32'(pv_seen - pv0), 32'(exp_pv));
      chk("dump_len", 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk($sformatf("dump_byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
   endtask

   task automatic abort_test(input int n);
      got.delete();
      send_cmd(8'h44);
      for (int i = 0; i < 500; i++) begin
         if (got.size() >= n) break;
         @(negedge clk);
      end
      chk("abort_reach", 32'(got.size() >= n), 32'd1);
      send_cmd(8'h52);
      mdl_cnt = 32'd0;
      chk("abort_tx_valid", 32'(tx_valid), 32'd0);
      chk("abort_pipe_reset", 32'(pipe_reset), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("abort_pipe_reset_pulse", 32'(pipe_reset), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      halt     = 1'b0;
      tx_ready = 1'b1;
      mdl_cnt  = 32'd0;
      for (int a = 0; a < N; a++) mem[a] = 32'hA000_0000 | 32'(a);

      repeat (5) @(negedge clk);
      chk("rst_pipe_reset", 32'(pipe_reset), 32'd1);
      chk("rst_pipe_valid", 32'(pipe_valid), 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_dbg_addr", 32'(dbg_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_pipe_reset", 32'(pipe_reset), 32'd0);

      repeat (3) do_cmd(8'h53, 0);

      send_cmd(8'h52);
      mdl_cnt = 32'd0;
      @(negedge clk);
      do_cmd(8'h43, 100);
      do_cmd(8'h43, 1);

      ready_mode = 1;
      do_cmd(8'h44, 0);
      ready_mode = 0;
      do_cmd(8'h44, 0);

      abort_test(6);
      do_cmd(8'h44, 0);

      for (int it = 0; it < 14; it++) begin
         for (int a = 0; a < N; a++) mem[a] = $urandom;
         ready_mode = $urandom_range(0, 2);
         send_cmd(8'h41);
         chk("unknown_ignored", 32'(busy), 32'd0);
         case ($urandom_range(0, 3))
            0:       do_cmd(8'h53, 0);
            1:       do_cmd(8'h44, 0);
            2:       do_cmd(8'h43, $urandom_range(1, 30));
            default: abort_test($urandom_range(1, 19));
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
Host-side controller that sits upstream of the MIPS pipeline top. It drives the pipeline's valid and reset inputs, and consumes pipeline state through a flat debug read port. The byte-command interface connects to the sibling UART block: commands reset, run, single-step and dump the machine, and dumps stream back as bytes. It also keeps the cycle counter that the pipeline top does not expose.

Parameters:
NB_REG, 32, width of each dumped word and of the cycle counter
NB_BYTE, 8, width of the rx/tx byte interface
N_DUMP_WORDS, 64, number of words read over the debug port per dump (PC, regfile, latches, data memory window)
NB_DBG_ADDR, clogb2(N_DUMP_WORDS), debug read address width (6 at default)

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_rx_data  in  NB_BYTE  received command byte
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid; no backpressure
o_tx_data  out  NB_BYTE  byte to transmit
o_tx_valid  out  1  o_tx_data valid
i_tx_ready  in  1  UART accepts byte
o_pipe_valid  out  1  pipeline advance enable (to pipeline i_valid)
o_pipe_reset  out  1  active-high pipeline reset (to pipeline i_reset)
i_halt  in  1  pipeline reports HALT reached
o_dbg_addr  out  NB_DBG_ADDR  debug read word index
i_dbg_data  in  NB_REG  debug read data, valid one cycle after o_dbg_addr
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (i_reset=0, async) values:
  - state IDLE
  - o_pipe_reset=1, o_pipe_valid=0, o_tx_valid=0, o_tx_data=0, o_dbg_addr=0, o_busy=0
  - cycle counter=0
- First clock after reset release drops o_pipe_reset to 0.
- States: IDLE, RUN, STEP, DUMP_ADDR, DUMP_LATCH, DUMP_SEND. All outputs are registered.
- Commands are sampled only when i_rx_valid=1. Commands that apply only in IDLE are ignored in other states. Unknown bytes are ignored.
- 'R' (0x52), accepted in any state:
  - o_pipe_reset=1 for exactly one cycle; counter cleared.
  - o_tx_valid dropped; go to IDLE. This aborts an in-progress dump, and no partial byte is resent.
- 'C' (0x43), IDLE only: go to RUN.
  - o_pipe_valid=1 every RUN cycle.
  - When i_halt=1 is sampled in RUN: o_pipe_valid=0 from the next cycle, go to DUMP_ADDR.
  - If i_halt is already 1 at entry, exactly one valid cycle occurs before the dump.
- 'S' (0x53), IDLE only: STEP.
  - o_pipe_valid=1 for exactly one cycle, then DUMP_ADDR.
  - i_halt is ignored in STEP.
- 'D' (0x44), IDLE only: go directly to DUMP_ADDR with no pipeline advance.
- Cycle counter:
  - +1 on every cycle with o_pipe_valid=1.
  - Wraps 0xFFFFFFFF to 0.
  - Cleared only by reset or 'R'.
- Dump sequence:
  - Word 0 is the cycle counter, snapshotted on entry to DUMP_ADDR.
  - Words 1..N_DUMP_WORDS are debug addresses 0..N_DUMP_WORDS-1.
  - DUMP_ADDR drives o_dbg_addr. DUMP_LATCH captures i_dbg_data into the shift register. DUMP_SEND emits 4 bytes, MSB first.
  - Total bytes per dump = 4*(N_DUMP_WORDS+1).
  - After the last byte is accepted: go to IDLE, o_dbg_addr returns to 0.
- Tx handshake:
  - A byte transfers on o_tx_valid & i_tx_ready.
  - o_tx_data is held stable while o_tx_valid & !i_tx_ready.
  - The next byte is presented the cycle after a transfer. With i_tx_ready tied high, throughput is 1 byte per cycle within a word.
- o_pipe_valid never asserts in DUMP_* states or in IDLE.

Optional Feature:
DEBUG_UNIT_CKSUM_EN:
- Defined: one extra byte is sent after the last dump byte. It is the XOR of all dump bytes, including the counter bytes, so the dump length becomes 4*(N_DUMP_WORDS+1)+1. 'R' during the checksum byte aborts as usual.
- Undefined: no checksum byte and no checksum logic.

Decomposition:
- Shared package (debug_pkg):
  - command byte constants CMD_RESET/CMD_CONT/CMD_STEP/CMD_DUMP
  - state encoding localparams
  - BYTES_PER_WORD=NB_REG/NB_BYTE
- One natural sub-module, dbg_word_serializer: loads an NB_REG word and emits bytes MSB-first with the valid/ready handshake and a last-byte flag. It is reused for the checksum byte.

Test Plan:
- Reset held low 5 cycles, released -> o_pipe_reset=1 during reset, 0 on the first cycle after; all other outputs 0.
- 'S' x3 with N_DUMP_WORDS=4, i_dbg_data=0xA0000000|addr, i_tx_ready=1 -> one o_pipe_valid pulse per command; each dump is 20 bytes; the third dump starts 00 00 00 03 A0 00 00 00.
- 'C', i_halt raised 100 cycles later -> exactly 100 o_pipe_valid cycles, counter word 0x00000064; i_dbg_data sampled one cycle after each address.
- i_tx_ready toggling 1/0 during dump -> o_tx_data stable while stalled; byte sequence identical to the ready=1 run.
- 'R' mid-dump after byte 6 -> o_tx_valid=0 next cycle, o_pipe_reset one-cycle pulse, counter 0, o_busy=0; a following 'D' gives a full dump starting 00 00 00 00.
- With DEBUG_UNIT_CKSUM_EN, 'D' with counter=0x01020304 and N_DUMP_WORDS=1, data 0x0F0F0F0F -> 9th byte 0x04.
